labs_search_scheduler: RTL and testbench

Sequences a LABS search run across PARALLEL_UNITS energy-evaluation units. It hands out candidate sequences base, base+1, … base+count-1 with round-robin dispatch and collects each unit's (sequence, energy) result. It tracks the minimum energy seen and signals completion. It sits between the Wishbone register front-end (cfg/start/status) and the search unit array.

---
 rtl/labs_search_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_labs_search_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/labs_search_scheduler.sv
// labs_search_scheduler
//   Sequences one LABS search run across PARALLEL_UNITS energy-evaluation units.
//   Candidates base .. base+count-1 are handed out in order with round-robin
//   dispatch. Each unit's (sequence, energy) result is collected with a second,
//   independent round-robin arbiter. The minimum energy and its sequence are
//   tracked, and completion is signalled.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   start, abort                  run control pulses
//   cfg_seq_base, cfg_count       run configuration, latched on start
//   unit_req_valid/ready/seq      one-hot dispatch handshake, shared candidate bus
//   unit_res_valid/seq/energy     per-unit result inputs, unit i at slice i
//   unit_res_ready                one-hot result accept
//   busy, done, done_pulse        run status
//   aborted                       last run ended by abort
//   best_energy, best_seq         minimum energy of the run and its sequence
//   issued_count, completed_count progress counters
module labs_search_scheduler #(
    parameter int SEQ_WIDTH      = 72,
    parameter int E_WIDTH        = 20,
    parameter int PARALLEL_UNITS = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic                                start,
    input  logic                                abort,
    input  logic [SEQ_WIDTH-1:0]                cfg_seq_base,
    input  logic [CNT_WIDTH-1:0]                cfg_count,
    output logic [PARALLEL_UNITS-1:0]           unit_req_valid,
    input  logic [PARALLEL_UNITS-1:0]           unit_req_ready,
    output logic [SEQ_WIDTH-1:0]                unit_req_seq,
    input  logic [PARALLEL_UNITS-1:0]           unit_res_valid,
    input  logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] unit_res_seq,
    input  logic [PARALLEL_UNITS*E_WIDTH-1:0]   unit_res_energy,
    output logic [PARALLEL_UNITS-1:0]           unit_res_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                done_pulse,
    output logic                                aborted,
    output logic [E_WIDTH-1:0]                  best_energy,
    output logic [SEQ_WIDTH-1:0]                best_seq,
    output logic [CNT_WIDTH-1:0]                issued_count,
    output logic [CNT_WIDTH-1:0]                completed_count
);

    localparam int PTR_W = (PARALLEL_UNITS > 1) ? $clog2(PARALLEL_UNITS) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                   state;
    logic [SEQ_WIDTH-1:0]     base_q;
    logic [CNT_WIDTH-1:0]     count_q;
    logic [PTR_W-1:0]         disp_ptr;
    logic [PTR_W-1:0]         res_ptr;

    logic                     disp_en;
    logic                     res_en;
    logic [PARALLEL_UNITS-1:0] req_grant;
    logic [PARALLEL_UNITS-1:0] res_grant;
    logic                     req_xfer;
    logic                     res_acc;
    logic [E_WIDTH-1:0]       sel_energy;
    logic [SEQ_WIDTH-1:0]     sel_seq;
    logic [CNT_WIDTH-1:0]     completed_next;
    logic [CNT_WIDTH-1:0]     issued_next;

    // First requester at or above ptr, wrapping. Scanning from the farthest
    // offset down lets the nearest hit overwrite earlier ones.
    function automatic logic [PARALLEL_UNITS-1:0] rr_pick(
        input logic [PARALLEL_UNITS-1:0] req,
        input logic [PTR_W-1:0]          ptr
    );
        logic [PARALLEL_UNITS-1:0] g;
        int idx;
        g = '0;
        for (int k = PARALLEL_UNITS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % PARALLEL_UNITS;
            if (req[idx]) begin
                g      = '0;
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    // Pointer moves to the slot just past the granted unit.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PARALLEL_UNITS-1:0] g);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < PARALLEL_UNITS; i++) begin
            if (g[i]) r = (i == PARALLEL_UNITS - 1) ? '0 : PTR_W'(i + 1);
        end
        return r;
    endfunction

    assign disp_en   = (state == DISPATCH) && (issued_count < count_q);
    assign res_en    = (state == DISPATCH) || (state == DRAIN);
    assign req_grant = disp_en ? rr_pick(unit_req_ready, disp_ptr) : '0;
    assign res_grant = res_en ? rr_pick(unit_res_valid, res_ptr) : '0;
    assign req_xfer  = |req_grant;
    assign res_acc   = |res_grant;

    assign unit_req_valid = req_grant;
    assign unit_res_ready = res_grant;
    // Candidate sequence wraps modulo 2^SEQ_WIDTH.
    assign unit_req_seq   = base_q + SEQ_WIDTH'(issued_count);
    assign busy           = res_en;

    assign issued_next    = issued_count + CNT_ONE;
    assign completed_next = res_acc ? completed_count + CNT_ONE : completed_count;

    always_comb begin
        sel_energy = '0;
        sel_seq    = '0;
        for (int i = 0; i < PARALLEL_UNITS; i++) begin
            if (res_grant[i]) begin
                sel_energy = unit_res_energy[i*E_WIDTH +: E_WIDTH];
                sel_seq    = unit_res_seq[i*SEQ_WIDTH +: SEQ_WIDTH];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= IDLE;
            base_q          <= '0;
            count_q         <= '0;
            disp_ptr        <= '0;
            res_ptr         <= '0;
            issued_count    <= '0;
            completed_count <= '0;
            best_energy     <= '1;
            best_seq        <= '0;
            done            <= 1'b0;
            done_pulse      <= 1'b0;
            aborted         <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base_q          <= cfg_seq_base;
                        count_q         <= cfg_count;
                        issued_count    <= '0;
                        completed_count <= '0;
                        aborted         <= 1'b0;
                        best_energy     <= '1;
                        best_seq        <= '0;
                        if (cfg_count == '0) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            done_pulse <= 1'b1;
                        end else begin
                            state <= DISPATCH;
                            done  <= 1'b0;
                        end
                    end
                end
                DISPATCH: begin
                    if (req_xfer) begin
                        issued_count <= issued_next;
                        disp_ptr     <= next_ptr(req_grant);
                    end
                    // A transfer in the abort cycle is still counted above.
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DRAIN;
                    end else if (req_xfer && (issued_next == count_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (completed_next == issued_count) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        done_pulse <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Result acceptance runs alongside dispatch; ties keep the earlier result.
            if (res_acc) begin
                completed_count <= completed_next;
                res_ptr         <= next_ptr(res_grant);
                if (sel_energy < best_energy) begin
                    best_energy <= sel_energy;
                    best_seq    <= sel_seq;
                end
            end
        end
    end

endmodule

// File: tb/tb_labs_search_scheduler.sv
module tb_labs_search_scheduler;

    localparam int SW = 72;
    localparam int EW = 20;
    localparam int PU = 2;
    localparam int CW = 32;

    localparam logic [SW-1:0] BIG_FF = {SW{1'b1}};
    localparam logic [SW-1:0] BIG_FE = {{(SW-8){1'b1}}, 8'hFE};

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [SW-1:0]  cfg_seq_base;
    logic [CW-1:0]  cfg_count;
    logic [PU-1:0]  unit_req_valid;
    logic [PU-1:0]  unit_req_ready;
    logic [SW-1:0]  unit_req_seq;
    logic [PU-1:0]  unit_res_valid;
    logic [PU*SW-1:0] unit_res_seq;
    logic [PU*EW-1:0] unit_res_energy;
    logic [PU-1:0]  unit_res_ready;
    logic           busy, done, done_pulse, aborted;
    logic [EW-1:0]  best_energy;
    logic [SW-1:0]  best_seq;
    logic [CW-1:0]  issued_count, completed_count;

    always #5 clk = ~clk;

    labs_search_scheduler #(
        .SEQ_WIDTH(SW), .E_WIDTH(EW), .PARALLEL_UNITS(PU), .CNT_WIDTH(CW)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
        .cfg_seq_base(cfg_seq_base), .cfg_count(cfg_count),
        .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready),
        .unit_req_seq(unit_req_seq), .unit_res_valid(unit_res_valid),
        .unit_res_seq(unit_res_seq), .unit_res_energy(unit_res_energy),
        .unit_res_ready(unit_res_ready), .busy(busy), .done(done),
        .done_pulse(done_pulse), .aborted(aborted), .best_energy(best_energy),
        .best_seq(best_seq), .issued_count(issued_count),
        .completed_count(completed_count)
    );

    typedef struct {
        logic          abt;
        logic [PU-1:0] rdy;
        logic [PU-1:0] rv;
        logic [SW-1:0] rs0, rs1;
        logic [EW-1:0] re0, re1;
        logic [PU-1:0] exp_valid;
        logic          chk_seq;
        logic [SW-1:0] exp_seq;
        logic [PU-1:0] exp_rready;
        logic          exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic abt, input logic [PU-1:0] rdy, input logic [PU-1:0] rv,
                                input logic [SW-1:0] rs0, input logic [SW-1:0] rs1,
                                input logic [EW-1:0] re0, input logic [EW-1:0] re1,
                                input logic [PU-1:0] ev, input logic cs, input logic [SW-1:0] es,
                                input logic [PU-1:0] err, input logic eb);
        vec_t v;
        v.abt = abt; v.rdy = rdy; v.rv = rv; v.rs0 = rs0; v.rs1 = rs1;
        v.re0 = re0; v.re1 = re1; v.exp_valid = ev; v.chk_seq = cs;
        v.exp_seq = es; v.exp_rready = err; v.exp_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [SW-1:0] base, input logic [CW-1:0] cnt);
        abort        = 1'b0;
        cfg_seq_base = base;
        cfg_count    = cnt;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            abort           = vecs[i].abt;
            unit_req_ready  = vecs[i].rdy;
            unit_res_valid  = vecs[i].rv;
            unit_res_seq    = {vecs[i].rs1, vecs[i].rs0};
            unit_res_energy = {vecs[i].re1, vecs[i].re0};
            #1;
            check($sformatf("%s[%0d] req_valid", tag, i - lo), 128'(unit_req_valid), 128'(vecs[i].exp_valid));
            if (vecs[i].chk_seq)
                check($sformatf("%s[%0d] req_seq", tag, i - lo), 128'(unit_req_seq), 128'(vecs[i].exp_seq));
            check($sformatf("%s[%0d] res_ready", tag, i - lo), 128'(unit_res_ready), 128'(vecs[i].exp_rready));
            check($sformatf("%s[%0d] busy", tag, i - lo), 128'(busy), 128'(vecs[i].exp_busy));
            tick();
        end
        abort = 1'b0;
    endtask

    // First DONE cycle checks, then one more cycle for pulse width.
    task automatic check_final(input string tag, input logic [EW-1:0] be, input logic [SW-1:0] bs,
                               input logic [CW-1:0] iss, input logic [CW-1:0] cmp, input logic ab);
        unit_req_ready = '1;
        unit_res_valid = '1;
        #1;
        check({tag, " done"}, 128'(done), 128'(1));
        check({tag, " done_pulse"}, 128'(done_pulse), 128'(1));
        check({tag, " busy"}, 128'(busy), 128'(0));
        check({tag, " best_energy"}, 128'(best_energy), 128'(be));
        check({tag, " best_seq"}, 128'(best_seq), 128'(bs));
        check({tag, " issued"}, 128'(issued_count), 128'(iss));
        check({tag, " completed"}, 128'(completed_count), 128'(cmp));
        check({tag, " aborted"}, 128'(aborted), 128'(ab));
        check({tag, " idle req_valid"}, 128'(unit_req_valid), 128'(0));
        check({tag, " idle res_ready"}, 128'(unit_res_ready), 128'(0));
        tick();
        check({tag, " done_pulse width"}, 128'(done_pulse), 128'(0));
        check({tag, " done held"}, 128'(done), 128'(1));
    endtask

    initial begin
        int t1, t3, t4, t5, t6a, t6b, tend;

        // Basic run: base 0x10, count 4, both units always ready.
        t1 = vecs.size();
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 1, 'h10, 2'b00, 1);
        add(0, 2'b11, 2'b01, 'h10, 0, 30, 0, 2'b10, 1, 'h11, 2'b01, 1);
        add(0, 2'b11, 2'b10, 0, 'h11, 0, 12, 2'b01, 1, 'h12, 2'b10, 1);
        add(0, 2'b11, 2'b01, 'h12, 0, 12, 0, 2'b10, 1, 'h13, 2'b01, 1);
        add(0, 2'b11, 2'b10, 0, 'h13, 0, 40, 2'b00, 0, 0, 2'b10, 1);
        // Sparse readiness, base 0x100, count 3 (pointers start at 0).
        t3 = vecs.size();
        add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        add(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b10, 1, 'h100, 2'b00, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        add(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b10, 1, 'h101, 2'b00, 1);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 1, 'h102, 2'b00, 1);
        add(0, 2'b11, 2'b11, 'h102, 'h100, 7, 9, 2'b00, 0, 0, 2'b01, 1);
        add(0, 2'b11, 2'b10, 0, 'h100, 0, 9, 2'b00, 0, 0, 2'b10, 1);
        add(0, 2'b11, 2'b10, 0, 'h101, 0, 3, 2'b00, 0, 0, 2'b10, 1);
        // Sequence wrap: base 2^72-2, count 3 (dispatch pointer starts at 1).
        t4 = vecs.size();
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 1, BIG_FE, 2'b00, 1);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 1, BIG_FF, 2'b00, 1);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 2'b00, 1);
        add(0, 2'b11, 2'b11, BIG_FF, BIG_FE, 6, 5, 2'b00, 0, 0, 2'b01, 1);
        add(0, 2'b11, 2'b11, 0, BIG_FE, 5, 5, 2'b00, 0, 0, 2'b10, 1);
        add(0, 2'b11, 2'b01, 0, 0, 5, 0, 2'b00, 0, 0, 2'b01, 1);
        // Abort after 5 issues with 2 outstanding (dispatch ptr 0, result ptr 1).
        t5 = vecs.size();
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 1, 0, 2'b00, 1);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 1, 1, 2'b00, 1);
        add(0, 2'b11, 2'b01, 0, 0, 50, 0, 2'b01, 1, 2, 2'b01, 1);
        add(0, 2'b11, 2'b10, 0, 1, 0, 20, 2'b10, 1, 3, 2'b10, 1);
        add(1, 2'b11, 2'b01, 2, 0, 60, 0, 2'b01, 1, 4, 2'b01, 1);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        add(0, 2'b11, 2'b11, 4, 3, 10, 10, 2'b00, 0, 0, 2'b10, 1);
        add(0, 2'b11, 2'b01, 4, 0, 10, 0, 2'b00, 0, 0, 2'b01, 1);
        // Run interrupted by reset (dispatch ptr starts at 1).
        t6a = vecs.size();
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b10, 1, 'h40, 2'b00, 1);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 1, 'h41, 2'b00, 1);
        // Run after reset: pointers back at 0.
        t6b = vecs.size();
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 1, 'h77, 2'b00, 1);
        add(0, 2'b11, 2'b01, 'h77, 0, 'h123, 0, 2'b00, 0, 0, 2'b01, 1);
        tend = vecs.size();

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_seq_base = '0; cfg_count = '0;
        unit_req_ready = '1; unit_res_valid = '1;
        unit_res_seq = '0; unit_res_energy = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset req_valid", 128'(unit_req_valid), 128'(0));
        check("reset res_ready", 128'(unit_res_ready), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset best_energy", 128'(best_energy), 128'(20'hFFFFF));
        check("reset issued", 128'(issued_count), 128'(0));
        check("reset req_seq", 128'(unit_req_seq), 128'(0));
        abort = 1'b1;          // abort while idle has no effect
        tick();
        abort = 1'b0;
        check("idle abort aborted", 128'(aborted), 128'(0));
        check("idle abort busy", 128'(busy), 128'(0));

        do_start('h10, 4);
        run_vecs(t1, t3, "basic");
        check_final("basic", 12, 'h11, 4, 4, 0);

        do_start('h55, 0);
        unit_req_ready = '1;
        #1;
        check("zero done", 128'(done), 128'(1));
        check("zero done_pulse", 128'(done_pulse), 128'(1));
        check("zero req_valid", 128'(unit_req_valid), 128'(0));
        check("zero best_energy", 128'(best_energy), 128'(20'hFFFFF));
        check("zero issued", 128'(issued_count), 128'(0));
        check("zero busy", 128'(busy), 128'(0));
        tick();
        check("zero done_pulse width", 128'(done_pulse), 128'(0));

        do_start('h100, 3);
        run_vecs(t3, t4, "sparse");
        check_final("sparse", 3, 'h101, 3, 3, 0);

        do_start(BIG_FE, 3);
        run_vecs(t4, t5, "wrap");
        check_final("wrap", 5, BIG_FE, 3, 3, 0);

        do_start(0, 100);
        run_vecs(t5, t6a, "abort");
        check_final("abort", 10, 3, 5, 5, 1);

        do_start('h40, 2);
        run_vecs(t6a, t6b, "prerst");
        unit_req_ready = '1;
        unit_res_valid = '1;
        #1;
        check("drain busy before reset", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst busy", 128'(busy), 128'(0));
        check("midrst req_valid", 128'(unit_req_valid), 128'(0));
        check("midrst res_ready", 128'(unit_res_ready), 128'(0));
        check("midrst issued", 128'(issued_count), 128'(0));
        check("midrst completed", 128'(completed_count), 128'(0));
        check("midrst best_energy", 128'(best_energy), 128'(20'hFFFFF));
        check("midrst best_seq", 128'(best_seq), 128'(0));
        check("midrst done", 128'(done), 128'(0));
        check("midrst aborted", 128'(aborted), 128'(0));
        tick();
        check("midrst stays idle", 128'(busy), 128'(0));

        do_start('h77, 1);
        run_vecs(t6b, tend, "postrst");
        check_final("postrst", 'h123, 'h77, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
